// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave bank of byte-strobed control registers with a read-only ID word at index 0.
// Write and read paths are independent; at most one write is in flight at a time.
module axil_reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int REG_COUNT = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'h12C0_0001
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
    output logic [REG_COUNT-1:0]            reg_wr
);
    localparam int IW = ADDR_WIDTH - 2;

    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IW-1:0]         awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic [REG_COUNT-1:0]  reg_wr_q, reg_wr_d;
    logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];
    logic [DATA_WIDTH-1:0] regs_d [1:REG_COUNT-1];
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, w_ok;
    logic [IW-1:0]         ar_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_ok;

    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    always_comb begin
        aw_hs     = s_axil_awvalid && awready_q;
        w_hs      = s_axil_wvalid && wready_q;
        b_hs      = bvalid_q && s_axil_bready;
        ar_hs     = s_axil_arvalid && arready_q;
        r_hs      = rvalid_q && s_axil_rready;
        // Commit fires once: bvalid blocks re-commit while the flags wait for the B handshake.
        commit    = aw_held_q && w_held_q && !bvalid_q;
        w_ok      = awidx_q != '0 && awidx_q < IW'(REG_COUNT);
        aw_held_d = !b_hs && (aw_held_q || aw_hs);
        w_held_d  = !b_hs && (w_held_q || w_hs);
        awidx_d   = aw_hs ? s_axil_awaddr[ADDR_WIDTH-1:2] : awidx_q;
        wdata_d   = w_hs ? s_axil_wdata : wdata_q;
        wstrb_d   = w_hs ? s_axil_wstrb : wstrb_q;
        bvalid_d  = commit || (bvalid_q && !b_hs);
        bresp_d   = commit ? (w_ok ? 2'b00 : 2'b10) : bresp_q;
        regs_d    = regs_q;
        reg_wr_d  = '0;
        for (int k = 1; k < REG_COUNT; k++) begin
            if (commit && w_ok && awidx_q == IW'(k)) begin
                reg_wr_d[k] = |wstrb_q;
                for (int b = 0; b < STRB_WIDTH; b++)
                    if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
        ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];
        rd_val = ar_idx == '0 ? ID_VALUE : '0;
        for (int k = 1; k < REG_COUNT; k++)
            if (ar_idx == IW'(k)) rd_val = regs_q[k];
        rvalid_d  = ar_hs || (rvalid_q && !r_hs);
        rdata_d   = ar_hs ? rd_val : rdata_q;
        rresp_d   = ar_hs ? {ar_idx >= IW'(REG_COUNT), 1'b0} : rresp_q;
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            reg_wr_q  <= '0;
            for (int k = 1; k < REG_COUNT; k++) regs_q[k] <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            reg_wr_q  <= reg_wr_d;
            regs_q    <= regs_d;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign reg_wr         = reg_wr_q;
    assign reg_out[DATA_WIDTH-1:0] = ID_VALUE;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: directed self-checking bench for axil_reg_bank.
module tb_axil_reg_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [511:0] reg_out;
    logic [15:0] reg_wr;
    int n_cmp = 0, n_bad = 0;
    logic [1:0]  resp;
    logic [15:0] wr;
    logic [31:0] data;

    axil_reg_bank dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .reg_out(reg_out), .reg_wr(reg_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] r, output logic [15:0] w);
        logic aw_go, w_go, got_b;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; got_b = 1'b0;
        for (int i = 0; i < 20 && !got_b; i++) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            got_b = bvalid;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_bvalid", bvalid, 1);
        r = bresp; w = reg_wr;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("wr_done", {bvalid, reg_wr}, 0);
    endtask

    task automatic read_word(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
        logic ok;
        ok = 1'b0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = arready;
            tick();
        end
        arvalid = 1'b0;
        chk("rd_rvalid", rvalid, 1);
        d = rdata; r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rd_done", rvalid, 0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready", {awready, wready, arready}, 0);
        chk("rst_valid", {bvalid, rvalid, bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_regwr", reg_wr, 0);
        chk("rst_id", reg_out[31:0], 32'h12C0_0001);
        chk("rst_reg3", reg_out[3*32 +: 32], 0);
        rst = 1'b1;
        chk("rel_pre", {awready, wready, arready}, 0);
        tick();
        chk("rel_post", {awready, wready, arready}, 3'b111);

        write_word(16'h000C, 32'hDEADBEEF, 4'hF, resp, wr);
        chk("w3_resp", resp, 0);
        chk("w3_pulse", wr, 16'h0008);
        chk("w3_reg", reg_out[3*32 +: 32], 32'hDEADBEEF);
        read_word(16'h000C, data, resp);
        chk("r3_data", data, 32'hDEADBEEF);
        chk("r3_resp", resp, 0);

        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("pw_awready", awready, 1);
        chk("pw_wready", wready, 0);
        tick();
        chk("pw_wait", {awready, bvalid, reg_out[3*32 +: 32]}, {2'b10, 32'hDEADBEEF});
        awaddr = 16'h000C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("pw_nob", bvalid, 0);
        tick();
        chk("pw_b", {bvalid, bresp}, 3'b100);
        chk("pw_pulse", reg_wr, 16'h0008);
        chk("pw_reg", reg_out[3*32 +: 32], 32'hDE22BE44);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        write_word(16'h0000, 32'hFFFFFFFF, 4'hF, resp, wr);
        chk("w0_resp", resp, 2'b10);
        chk("w0_pulse", wr, 0);
        chk("w0_id", reg_out[31:0], 32'h12C0_0001);
        read_word(16'h0000, data, resp);
        chk("r0_data", {data, resp}, {32'h12C0_0001, 2'b00});
        read_word(16'h0040, data, resp);
        chk("roob_data", data, 0);
        chk("roob_resp", resp, 2'b10);
        write_word(16'h0040, 32'h5555AAAA, 4'hF, resp, wr);
        chk("woob", {resp, wr}, {2'b10, 16'h0});

        write_word(16'h0014, 32'hA5A5A5A5, 4'hF, resp, wr);
        chk("w5_pulse", {resp, wr}, {2'b00, 16'h0020});
        write_word(16'h0014, 32'h00000000, 4'h0, resp, wr);
        chk("w5z_resp", resp, 0);
        chk("w5z_pulse", wr, 0);
        chk("w5z_reg", reg_out[5*32 +: 32], 32'hA5A5A5A5);
        write_word(16'h003F, 32'hCAFEF00D, 4'hF, resp, wr);
        chk("w15", {resp, wr}, {2'b00, 16'h8000});
        read_word(16'h003C, data, resp);
        chk("r15", {data, resp}, {32'hCAFEF00D, 2'b00});

        awaddr = 16'h0008; wdata = 32'h01020304; wstrb = 4'hF; araddr = 16'h000C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("bp_rd", {rvalid, rdata, rresp}, {1'b1, 32'hDE22BE44, 2'b00});
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {bvalid, rvalid, awready, wready, arready}, 5'b11000);
            chk("bp_data", {rdata, bresp}, {32'hDE22BE44, 2'b00});
            tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("bp_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
        chk("bp_reg2", reg_out[2*32 +: 32], 32'h01020304);

        awaddr = 16'h0018; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("mr_held", {awready, wready}, 2'b01);
        rst = 1'b0;
        #1;
        chk("mr_rst", {awready, wready, arready, bvalid, rvalid}, 0);
        chk("mr_regs", {reg_out[3*32 +: 32], reg_out[6*32 +: 32]}, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_idle", {bvalid, reg_wr, reg_out[6*32 +: 32]}, 0);
        end
        write_word(16'h0018, 32'h0BADF00D, 4'hF, resp, wr);
        chk("mr_w", {resp, wr}, {2'b00, 16'h0040});
        chk("mr_reg6", reg_out[6*32 +: 32], 32'h0BADF00D);
        read_word(16'h0018, data, resp);
        chk("mr_r", {data, resp}, {32'h0BADF00D, 2'b00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axil_reg_bank.md
# axil_reg_bank

AXI4-Lite slave register bank that sits directly downstream of the I2C-slave-to-AXI-Lite bridge. It terminates the bridge's `m_axil_*` master port. It turns I2C-initiated register reads and writes into a bank of byte-strobed control registers, exposed in parallel to the surrounding logic. It also provides a read-only ID word so software can identify the bank over I2C.

## Interface
Parameters:
- `DATA_WIDTH`, 32: AXI-Lite data width; must be 32.
- `ADDR_WIDTH`, 16: AXI-Lite byte address width.
- `STRB_WIDTH`, `DATA_WIDTH/8`: write strobe width.
- `REG_COUNT`, 16: number of word registers; range 2..64.
- `ID_VALUE`, 32'h12C0_0001: constant returned by register 0.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `s_axil_awaddr` in ADDR_WIDTH: write address.
- `s_axil_awprot` in 3: ignored.
- `s_axil_awvalid` in 1; `s_axil_awready` out 1.
- `s_axil_wdata` in DATA_WIDTH; `s_axil_wstrb` in STRB_WIDTH; `s_axil_wvalid` in 1; `s_axil_wready` out 1.
- `s_axil_bresp` out 2; `s_axil_bvalid` out 1; `s_axil_bready` in 1.
- `s_axil_araddr` in ADDR_WIDTH; `s_axil_arprot` in 3 (ignored); `s_axil_arvalid` in 1; `s_axil_arready` out 1.
- `s_axil_rdata` out DATA_WIDTH; `s_axil_rresp` out 2; `s_axil_rvalid` out 1; `s_axil_rready` in 1.
- `reg_out` out REG_COUNT*DATA_WIDTH: register k occupies bits [k*32 +: 32]. Slice 0 is always `ID_VALUE`.
- `reg_wr` out REG_COUNT: one-cycle pulse per register updated by a write commit.

## Operation
- Word index is `addr[ADDR_WIDTH-1:2]`. `addr[1:0]` is ignored.
- Index 0 is the read-only ID register. Indices 1..REG_COUNT-1 are read/write. Index ≥ REG_COUNT is out of range.
- Write path uses two independent capture flags, `aw_held` and `w_held`.
  - `awready = !aw_held`, `wready = !w_held`.
  - Each handshake latches its payload and sets its flag. AW and W may arrive in either order or in the same cycle.
- Write commit happens on the first edge where both flags are set:
  - For each byte i with `wstrb[i]=1`, that byte of the target register is updated.
  - `reg_wr[idx]` pulses if any strobe bit is set.
  - `bvalid` is set, with `bresp` as follows:
    - OKAY (2'b00) for indices 1..REG_COUNT-1, including the `wstrb=0` case (no change, no pulse).
    - SLVERR (2'b10) for index 0 or out-of-range; no register change and no pulse.
- Both flags stay set until the B handshake (`bvalid && bready`). At that edge `bvalid` and both flags clear. There is at most one write in flight.
- Read path: `arready = !rvalid`.
  - An AR handshake at an edge loads `rdata`/`rresp` and sets `rvalid`, all at that same edge.
  - Index 0 returns `ID_VALUE`, OKAY. In-range indices return the register value, OKAY. Out-of-range returns 0, SLVERR.
  - `rvalid`, `rdata` and `rresp` stay stable until `rready`. The R handshake clears `rvalid`.
- Read and write paths are fully independent and run concurrently.

## Timing
- Reset (`rst=0`, asynchronous) drives all of the following to 0:
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid`
  - `bresp`, `rresp`, `rdata`
  - all RW registers, `reg_wr`, and the capture flags
- Ready signals are registered copies of the equations above. They first assert on the first `clk` edge after `rst` deasserts.
- Write latency: the last of AW/W handshakes at edge N → register updated, `reg_wr` high and `bvalid` high after edge N+1. `reg_wr` drops after edge N+2.
- Minimum write period is 3 cycles: capture, commit, B handshake. `awready`/`wready` reassert the cycle after the B handshake.
- Read latency: AR handshake at edge N → `rvalid` high after edge N. Back-to-back reads are possible every 2 cycles with `rready` held high.
- Read and write commit on the same register at the same edge: the read returns the pre-write value.
- `bvalid`/`rvalid` never drop without the matching ready, regardless of other channel activity.
- Reset mid-transaction discards all held payloads and pending responses immediately. No partial register update occurs.

## Test plan
- Reset: hold `rst=0` for 5 cycles → all outputs 0; `reg_out` slice 0 = 32'h12C0_0001; readies high one cycle after release.
- Write 32'hDEADBEEF with `wstrb` 4'hF to addr 16'h000C, then read 16'h000C → `bresp` 0; `reg_wr[3]` pulses once; `rdata` 32'hDEADBEEF, `rresp` 0.
- Partial strobe: with reg 3 = 32'hDEADBEEF, W (32'h11223344, `wstrb` 4'b0101) one cycle before AW → reg 3 = 32'hDE22BE44; `awready` stays high until AW arrives.
- Error cases:
  - Write to 16'h0000 → SLVERR; ID unchanged.
  - Read of 16'h0040 (index 16) → `rdata` 0, `rresp` 2'b10.
  - `wstrb=0` write → OKAY, no pulse.
- Backpressure: hold `bready`/`rready` low for 10 cycles → `bvalid`/`rvalid`/data stable; `awready`, `wready`, `arready` low throughout; release → responses complete, readies reassert.
- Assert `rst` the cycle after AW capture but before W → no register change, no `bvalid`; the next full write behaves normally.
